pmbus_poll_seq: RTL and testbench
=================================

// Module: pmbus_poll_seq
// PURPOSE
//  Multi-device PMBus telemetry sequencer; successor to the single-shot TPS546C20A command layer.
//  Drives the existing I2C byte engine (recv/send enables, done pulse) to read N_CMD commands from
//  each of N_DEV regulators per sweep, with an optional PAGE write per device.
//  Results go to a register file read by the host; sweeps run single-shot or periodic.
// PARAMETERS
//  N_DEV         4      number of devices polled per sweep (1..8)
//  N_CMD         4      commands read per device (1..8)
//  INTERVAL_CYC  40000  idle cycles between periodic sweeps (10 ms at 4 MHz)
//  TIMEOUT_CYC   8000   max cycles waiting for I_done_pulse (used only with PMBUS_POLL_TIMEOUT_EN)
// PORTS
//  I_CLK_4M      in   1            4 MHz clock
//  I_rst_n       in   1            async active-low reset
//  I_start_pulse in   1            start sweep (1-cycle pulse)
//  I_continuous  in   1            1: re-sweep after INTERVAL_CYC
//  I_page_en     in   1            1: write PAGE (0x00) = I_page before each device's reads
//  I_page        in   8            PAGE value
//  I_dev_tbl     in   7*N_DEV      device addresses, dev0 in LSBs
//  I_cmd_tbl     in   8*N_CMD      command codes, cmd0 in LSBs
//  I_len_tbl     in   2*N_CMD      bytes per command (0 = skip, 1, 2; 3 treated as 2)
//  O_recv_en     out  1            engine read enable
//  O_send_en     out  1            engine write enable
//  O_dev_addr    out  7            engine device address
//  O_cmd_addr    out  8            engine command code
//  O_write_data  out  16           engine write data ({8'h00,I_page})
//  O_BYTE        out  2            engine byte count
//  I_done_pulse  in   1            engine transaction done
//  I_read_data   in   16           engine read data, valid with I_done_pulse
//  I_rd_idx      in   6            host read index = dev*N_CMD+cmd
//  O_rd_data     out  16           result, 1-cycle latency
//  O_rd_err      out  1            entry timed out in last sweep
//  O_busy        out  1            sweep in progress
//  O_fh_pulse    out  1            1-cycle pulse at sweep end
//  O_err         out  1            sticky: any timeout since last start
// BEHAVIOUR
//  Reset: all outputs 0; results 16'h0000; err bits 0; FSM IDLE.
//  FSM: IDLE -> (start) PAGE_REQ|RD_REQ -> WAIT -> NEXT -> ... -> DONE -> IDLE|GAP -> (INTERVAL_CYC) sweep.
//  REQ: drive addr/cmd/BYTE and raise exactly one enable next cycle; hold until I_done_pulse.
//  WAIT: on I_done_pulse drop enable same edge, store result, go NEXT; >=1 idle cycle between transactions.
//  Storage: 2-byte -> I_read_data; 1-byte -> {8'h00,I_read_data[7:0]}; entry err bit cleared.
//  Len 0: no transaction, entry unchanged. PAGE write result discarded.
//  Order: dev0 [PAGE] cmd0..cmdN-1, dev1 ..., wraps only via new sweep.
//  O_fh_pulse in DONE; O_busy high from start accepted through DONE (low in GAP).
//  Start while busy ignored; start in GAP begins sweep immediately. O_err cleared on accepted start.
//  I_continuous low during sweep/GAP: finish sweep, then IDLE (GAP aborted).
//  I_done_pulse outside WAIT ignored. Tables static while O_busy (sampled live).
//  I_rd_idx >= N_DEV*N_CMD -> O_rd_data 0, O_rd_err 0. Host read same cycle as write returns old value.
//  Reset mid-transaction: enables drop asynchronously, sweep abandoned.
// CONFIGURATION
//  PMBUS_POLL_TIMEOUT_EN defined: counter in WAIT; at TIMEOUT_CYC drop enable, store 16'hFFFF,
//   set entry err bit and O_err, continue; stay idle 16 cycles before next REQ.
//  Undefined: WAIT indefinite; O_err, O_rd_err tied 0.
// STRUCTURE
//  pmbus_pkg: FSM state encoding, PMBUS_PAGE_CMD=8'h00, index widths, ERR_DATA=16'hFFFF.
//  Sub-module pmbus_result_ram: N_DEV*N_CMD x 17b (data+err), 1 write port, registered read port.
// TESTING
//  Engine BFM, N_DEV=2, N_CMD=2, len {2,1}: start -> 4 reads in order; idx1 = 16'h00AB for BFM data 16'h12AB.
//  I_page_en=1, I_page=8'h03 -> send_en write 0x0003 cmd 0x00 before each device's reads, 6 transactions.
//  I_continuous=1, INTERVAL_CYC=100 -> second sweep starts 100 cycles after first O_fh_pulse; drop continuous -> IDLE.
//  TIMEOUT_EN, BFM withholds done for dev1 cmd0 -> idx2 = 16'hFFFF, O_rd_err=1, O_err=1, sweep completes.
//  Reset asserted mid-WAIT -> O_recv_en 0 immediately, results 0, O_busy 0.
//  Start during sweep and done pulse in IDLE -> no extra transactions, no stored change.

Source files
------------

// File: rtl/pmbus_pkg.sv
// Shared types and constants for the PMBus telemetry poll sequencer.
// Optional timeout support in pmbus_poll_seq is enabled with PMBUS_POLL_TIMEOUT_EN.
package pmbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAGE_REQ,
      ST_RD_REQ,
      ST_WAIT,
      ST_NEXT,
      ST_HOLD,
      ST_DONE,
      ST_GAP
   } state_t;

   localparam logic [7:0]  PMBUS_PAGE_CMD = 8'h00;
   localparam logic [15:0] ERR_DATA       = 16'hFFFF;
   localparam int          IDX_W          = 6;
   localparam int          SEL_W          = 3;
   localparam int          MAX_TBL        = 8;
   localparam int          HOLD_CYC       = 16;

   // A length code of 3 is read as a 2-byte word.
   function automatic logic [1:0] eff_len(input logic [1:0] raw);
      return (raw == 2'd3) ? 2'd2 : raw;
   endfunction

endpackage

// File: rtl/pmbus_result_ram.sv
// Result store for the poll sequencer: {err, data[15:0]} per entry, one write port,
// registered read port; out-of-range reads return zero.
module pmbus_result_ram
   import pmbus_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [15:0]      wdata,
   input  logic             werr,
   input  logic [IDX_W-1:0] raddr,
   output logic [15:0]      rdata,
   output logic             rerr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [16:0] mem [2**AW];
   logic        raddr_ok;

   assign raddr_ok = ({1'b0, raddr} < 7'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
         rdata <= '0;
         rerr  <= 1'b0;
      end else begin
         if (we) mem[waddr[AW-1:0]] <= {werr, wdata};
         if (raddr_ok) {rerr, rdata} <= mem[raddr[AW-1:0]];
         else          {rerr, rdata} <= '0;
      end
   end

endmodule

// File: rtl/pmbus_poll_seq.sv
// Multi-device PMBus telemetry sequencer driving the I2C byte engine; per-transaction
// timeout and error reporting are built only when PMBUS_POLL_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start
// PAGE_REQ | present PAGE write for current device
// RD_REQ   | present read of current command (len 0 skips)
// WAIT     | enable high, waiting for engine done
// NEXT     | idle cycle, advance command/device
// HOLD     | idle backoff after a timeout
// DONE     | sweep finished, fh pulse
// GAP      | interval between periodic sweeps
module pmbus_poll_seq
   import pmbus_pkg::*;
#(
   parameter int N_DEV        = 4,
   parameter int N_CMD        = 4,
   parameter int INTERVAL_CYC = 40000,
   parameter int TIMEOUT_CYC  = 8000
) (
   input  logic               I_CLK_4M,
   input  logic               I_rst_n,
   input  logic               I_start_pulse,
   input  logic               I_continuous,
   input  logic               I_page_en,
   input  logic [7:0]         I_page,
   input  logic [7*N_DEV-1:0] I_dev_tbl,
   input  logic [8*N_CMD-1:0] I_cmd_tbl,
   input  logic [2*N_CMD-1:0] I_len_tbl,
   output logic               O_recv_en,
   output logic               O_send_en,
   output logic [6:0]         O_dev_addr,
   output logic [7:0]         O_cmd_addr,
   output logic [15:0]        O_write_data,
   output logic [1:0]         O_BYTE,
   input  logic               I_done_pulse,
   input  logic [15:0]        I_read_data,
   input  logic [5:0]         I_rd_idx,
   output logic [15:0]        O_rd_data,
   output logic               O_rd_err,
   output logic               O_busy,
   output logic               O_fh_pulse,
   output logic               O_err
);

   localparam int DEPTH   = N_DEV * N_CMD;
   localparam int CNT_MAX = (INTERVAL_CYC > TIMEOUT_CYC) ? INTERVAL_CYC : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state_q, state_nxt;
   logic [SEL_W-1:0]   dev_idx, cmd_idx;
   logic               page_phase;
   logic [CNT_W-1:0]   cnt;
   logic               sweep_go, store, tmo, set_recv, set_send, clr_en;
   logic               last_cmd, last_dev, active;
   logic [1:0]         cur_len;
   logic [IDX_W-1:0]   entry_idx;
   logic [15:0]        ram_wdata;
   logic               ram_we;
   logic               ram_rerr;

   logic [6:0] dev_arr [MAX_TBL];
   logic [7:0] cmd_arr [MAX_TBL];
   logic [1:0] len_arr [MAX_TBL];

   for (genvar i = 0; i < MAX_TBL; i++) begin : g_tbl
      if (i < N_DEV) begin : g_dev
         assign dev_arr[i] = I_dev_tbl[7*i +: 7];
      end else begin : g_dev_pad
         assign dev_arr[i] = '0;
      end
      if (i < N_CMD) begin : g_cmd
         assign cmd_arr[i] = I_cmd_tbl[8*i +: 8];
         assign len_arr[i] = I_len_tbl[2*i +: 2];
      end else begin : g_cmd_pad
         assign cmd_arr[i] = '0;
         assign len_arr[i] = '0;
      end
   end

   assign cur_len   = eff_len(len_arr[cmd_idx]);
   assign last_cmd  = (cmd_idx == SEL_W'(N_CMD - 1));
   assign last_dev  = (dev_idx == SEL_W'(N_DEV - 1));
   assign entry_idx = IDX_W'(dev_idx) * IDX_W'(N_CMD) + IDX_W'(cmd_idx);

   assign active       = (state_q == ST_PAGE_REQ) || (state_q == ST_RD_REQ) || (state_q == ST_WAIT);
   assign O_dev_addr   = active ? dev_arr[dev_idx] : '0;
   assign O_cmd_addr   = active ? (page_phase ? PMBUS_PAGE_CMD : cmd_arr[cmd_idx]) : '0;
   assign O_BYTE       = active ? (page_phase ? 2'd1 : cur_len) : '0;
   assign O_write_data = (active && page_phase) ? {8'h00, I_page} : '0;
   assign O_busy       = (state_q != ST_IDLE) && (state_q != ST_GAP);
   assign O_fh_pulse   = (state_q == ST_DONE);

   always_ff @(posedge I_CLK_4M or negedge I_rst_n) begin
      if (!I_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      sweep_go  = 1'b0;
      store     = 1'b0;
      tmo       = 1'b0;
      set_recv  = 1'b0;
      set_send  = 1'b0;
      clr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_start_pulse) begin
               sweep_go  = 1'b1;
               state_nxt = I_page_en ? ST_PAGE_REQ : ST_RD_REQ;
            end
         end
         ST_PAGE_REQ: begin
            set_send  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_RD_REQ: begin
            if (cur_len == 2'd0) begin
               state_nxt = ST_NEXT;
            end else begin
               set_recv  = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (I_done_pulse) begin
               clr_en    = 1'b1;
               store     = !page_phase;
               state_nxt = ST_NEXT;
            end
`ifdef PMBUS_POLL_TIMEOUT_EN
            else if (cnt == '0) begin
               clr_en    = 1'b1;
               tmo       = 1'b1;
               state_nxt = ST_HOLD;
            end
`endif
         end
         ST_NEXT: begin
            if (page_phase || !last_cmd) state_nxt = ST_RD_REQ;
            else if (last_dev)           state_nxt = ST_DONE;
            else if (I_page_en)          state_nxt = ST_PAGE_REQ;
            else                         state_nxt = ST_RD_REQ;
         end
         ST_HOLD: begin
            if (cnt == '0) state_nxt = ST_NEXT;
         end
         ST_DONE: begin
            state_nxt = I_continuous ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (!I_continuous) begin
               state_nxt = ST_IDLE;
            end else if (I_start_pulse || cnt == '0) begin
               sweep_go  = 1'b1;
               state_nxt = I_page_en ? ST_PAGE_REQ : ST_RD_REQ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_CLK_4M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         dev_idx    <= '0;
         cmd_idx    <= '0;
         page_phase <= 1'b0;
         cnt        <= '0;
         O_recv_en  <= 1'b0;
         O_send_en  <= 1'b0;
      end else begin
         if (clr_en) begin
            O_recv_en <= 1'b0;
            O_send_en <= 1'b0;
         end else begin
            if (set_recv) O_recv_en <= 1'b1;
            if (set_send) O_send_en <= 1'b1;
         end

         if (sweep_go) begin
            dev_idx    <= '0;
            cmd_idx    <= '0;
            page_phase <= I_page_en;
         end else if (state_q == ST_NEXT) begin
            if (page_phase) begin
               page_phase <= 1'b0;
            end else if (!last_cmd) begin
               cmd_idx <= cmd_idx + 1'b1;
            end else if (!last_dev) begin
               dev_idx    <= dev_idx + 1'b1;
               cmd_idx    <= '0;
               page_phase <= I_page_en;
            end
         end

         // One down-counter serves the WAIT timeout, the post-timeout backoff and the sweep gap.
         if (set_recv || set_send)     cnt <= CNT_W'(TIMEOUT_CYC - 1);
         else if (tmo)                 cnt <= CNT_W'(HOLD_CYC - 2);
         else if (state_q == ST_DONE)  cnt <= CNT_W'(INTERVAL_CYC - 2);
         else if (cnt != '0 && (state_q == ST_WAIT || state_q == ST_HOLD || state_q == ST_GAP))
            cnt <= cnt - 1'b1;
      end
   end

`ifdef PMBUS_POLL_TIMEOUT_EN
   logic err_q;

   always_ff @(posedge I_CLK_4M or negedge I_rst_n) begin
      if (!I_rst_n)      err_q <= 1'b0;
      else if (sweep_go) err_q <= 1'b0;
      else if (tmo)      err_q <= 1'b1;
   end

   assign O_err    = err_q;
   assign O_rd_err = ram_rerr;
`else
   assign O_err    = 1'b0;
   // Only the timeout path ever writes a set err bit, so this reads as zero here.
   assign O_rd_err = ram_rerr;
`endif

   assign ram_we    = store || (tmo && !page_phase);
   assign ram_wdata = tmo ? ERR_DATA
                    : (cur_len == 2'd1) ? {8'h00, I_read_data[7:0]} : I_read_data;

   pmbus_result_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (I_CLK_4M),
      .rst_n (I_rst_n),
      .we    (ram_we),
      .waddr (entry_idx),
      .wdata (ram_wdata),
      .werr  (tmo),
      .raddr (I_rd_idx),
      .rdata (O_rd_data),
      .rerr  (ram_rerr)
   );

endmodule

// File: tb/tb_pmbus_poll_seq.sv
// Scoreboard bench for pmbus_poll_seq with an engine BFM; timeout cases are
// exercised when PMBUS_POLL_TIMEOUT_EN is defined.
module tb_pmbus_poll_seq;

   localparam int N_DEV = 2;
   localparam int N_CMD = 2;

   typedef struct packed {
      logic        wr;
      logic [6:0]  dev;
      logic [7:0]  cmd;
      logic [1:0]  nb;
      logic [15:0] wd;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        page_en = 1'b0;
   logic [7:0]  page = 8'h00;
   logic [13:0] dev_tbl = {7'h34, 7'h12};
   logic [15:0] cmd_tbl = {8'hAB, 8'h8B};
   logic [3:0]  len_tbl = {2'd1, 2'd2};
   logic        recv_en, send_en;
   logic [6:0]  dev_addr;
   logic [7:0]  cmd_addr;
   logic [15:0] write_data;
   logic [1:0]  nbyte;
   logic        done;
   logic        bfm_done, stray_done = 1'b0;
   logic [15:0] read_data;
   logic [5:0]  rd_idx = 6'd0;
   logic [15:0] rd_data;
   logic        rd_err, busy, fh_pulse, err;
   logic        withhold = 1'b0;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   txn_t exp_q[$];

   assign done = bfm_done | stray_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmbus_poll_seq #(
      .N_DEV(N_DEV), .N_CMD(N_CMD), .INTERVAL_CYC(100), .TIMEOUT_CYC(50)
   ) dut (
      .I_CLK_4M(clk), .I_rst_n(rst_n), .I_start_pulse(start), .I_continuous(continuous),
      .I_page_en(page_en), .I_page(page), .I_dev_tbl(dev_tbl), .I_cmd_tbl(cmd_tbl),
      .I_len_tbl(len_tbl), .O_recv_en(recv_en), .O_send_en(send_en), .O_dev_addr(dev_addr),
      .O_cmd_addr(cmd_addr), .O_write_data(write_data), .O_BYTE(nbyte), .I_done_pulse(done),
      .I_read_data(read_data), .I_rd_idx(rd_idx), .O_rd_data(rd_data), .O_rd_err(rd_err),
      .O_busy(busy), .O_fh_pulse(fh_pulse), .O_err(err)
   );

   // Engine BFM: answers each enable after two cycles with data {0, dev, cmd}.
   initial begin
      bfm_done  = 1'b0;
      read_data = 16'h0000;
      forever begin
         @(negedge clk);
         if ((recv_en || send_en) &&
             !(withhold && recv_en && dev_addr == 7'h34 && cmd_addr == 8'h8B)) begin
            repeat (2) @(negedge clk);
            read_data = {1'b0, dev_addr, cmd_addr};
            bfm_done  = 1'b1;
            @(negedge clk);
            bfm_done  = 1'b0;
         end
      end
   end

   // Monitor: every new engine transaction is popped against the scoreboard.
   initial begin
      logic prev;
      txn_t got, e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (recv_en && send_en) begin
            errors++;
            $display("FAIL both_enables recv=%b send=%b required one-hot", recv_en, send_en);
         end
         if ((recv_en || send_en) && !prev) begin
            checks++;
            got = {send_en, dev_addr, cmd_addr, nbyte, send_en ? write_data : 16'h0000};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL txn_unexpected got=%h required none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL txn got=%h required=%h", got, e);
               end
            end
         end
         prev = recv_en || send_en;
      end
   end

   task automatic push(input logic wr, input logic [6:0] d, input logic [7:0] c,
                       input logic [1:0] nb, input logic [15:0] wd);
      txn_t t;
      t = {wr, d, c, nb, wd};
      exp_q.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h required=%h", nm, got, exp);
      end
   endtask

   task automatic rd_chk(input string nm, input logic [5:0] idx, input logic [15:0] d,
                         input logic e);
      @(negedge clk);
      rd_idx = idx;
      @(posedge clk);
      #1;
      chk(nm, {47'h0, rd_err, rd_data}, {47'h0, e, d});
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fh(input string nm, input int max);
      int n;
      n = 0;
      checks++;
      do begin
         @(negedge clk);
         n++;
      end while (!fh_pulse && n < max);
      if (!fh_pulse) begin
         errors++;
         $display("FAIL %s no fh_pulse within %0d cycles", nm, max);
      end
   endtask

   task automatic push_base();
      push(1'b0, 7'h12, 8'h8B, 2'd2, 16'h0);
      push(1'b0, 7'h12, 8'hAB, 2'd1, 16'h0);
      push(1'b0, 7'h34, 8'h8B, 2'd2, 16'h0);
      push(1'b0, 7'h34, 8'hAB, 2'd1, 16'h0);
   endtask

   initial begin
      int  c1, n;
      logic seen;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outs", {9'h0, recv_en, send_en, busy, fh_pulse, err, rd_err, dev_addr,
                         cmd_addr, nbyte, write_data, rd_data}, 64'h0);
      rst_n = 1'b1;
      rd_chk("reset_idx0", 6'd0, 16'h0000, 1'b0);

      // Basic sweep, lengths {2,1}
      push_base();
      pulse_start();
      chk("busy_on", {63'h0, busy}, 64'h1);
      wait_fh("t1_fh", 500);
      repeat (2) @(negedge clk);
      chk("t1_left", 64'(exp_q.size()), 64'h0);
      chk("t1_busy_off", {63'h0, busy}, 64'h0);
      rd_chk("t1_idx0", 6'd0, 16'h128B, 1'b0);
      rd_chk("t1_idx1", 6'd1, 16'h00AB, 1'b0);
      rd_chk("t1_idx2", 6'd2, 16'h348B, 1'b0);
      rd_chk("t1_idx3", 6'd3, 16'h00AB, 1'b0);
      rd_chk("t1_oor", 6'd4, 16'h0000, 1'b0);
      chk("t1_err", {63'h0, err}, 64'h0);

      // PAGE write before each device
      page_en = 1'b1;
      page    = 8'h03;
      push(1'b1, 7'h12, 8'h00, 2'd1, 16'h0003);
      push(1'b0, 7'h12, 8'h8B, 2'd2, 16'h0);
      push(1'b0, 7'h12, 8'hAB, 2'd1, 16'h0);
      push(1'b1, 7'h34, 8'h00, 2'd1, 16'h0003);
      push(1'b0, 7'h34, 8'h8B, 2'd2, 16'h0);
      push(1'b0, 7'h34, 8'hAB, 2'd1, 16'h0);
      pulse_start();
      wait_fh("t2_fh", 800);
      repeat (2) @(negedge clk);
      chk("t2_left", 64'(exp_q.size()), 64'h0);
      page_en = 1'b0;

      // Length 3 reads two bytes, length 0 skipped and leaves entry unchanged
      cmd_tbl = {8'hAB, 8'h8C};
      len_tbl = {2'd0, 2'd3};
      push(1'b0, 7'h12, 8'h8C, 2'd2, 16'h0);
      push(1'b0, 7'h34, 8'h8C, 2'd2, 16'h0);
      pulse_start();
      wait_fh("t2b_fh", 500);
      repeat (2) @(negedge clk);
      chk("t2b_left", 64'(exp_q.size()), 64'h0);
      rd_chk("t2b_idx0", 6'd0, 16'h128C, 1'b0);
      rd_chk("t2b_idx1", 6'd1, 16'h00AB, 1'b0);
      rd_chk("t2b_idx2", 6'd2, 16'h348C, 1'b0);
      cmd_tbl = {8'hAB, 8'h8B};
      len_tbl = {2'd1, 2'd2};

      // Periodic sweeps
      continuous = 1'b1;
      push_base();
      push_base();
      pulse_start();
      wait_fh("t3_fh1", 500);
      c1 = cyc;
      n  = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 300);
      chk("t3_gap", 64'(cyc - c1), 64'd100);
      continuous = 1'b0;
      wait_fh("t3_fh2", 500);
      seen = 1'b0;
      repeat (150) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("t3_idle_after", {63'h0, seen}, 64'h0);
      chk("t3_left", 64'(exp_q.size()), 64'h0);

      // Start while busy and stray done in IDLE are ignored
      push_base();
      pulse_start();
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_fh("t4_fh", 500);
      repeat (10) @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_left", 64'(exp_q.size()), 64'h0);
      chk("t4_busy", {63'h0, busy}, 64'h0);
      rd_chk("t4_idx0", 6'd0, 16'h128B, 1'b0);
      rd_chk("t4_idx3", 6'd3, 16'h00AB, 1'b0);

      // Reset in the middle of WAIT
      push(1'b0, 7'h12, 8'h8B, 2'd2, 16'h0);
      pulse_start();
      n = 0;
      while (!recv_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_saw_recv", {63'h0, recv_en}, 64'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {62'h0, recv_en, busy}, 64'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rd_chk("t5_idx0", 6'd0, 16'h0000, 1'b0);
      rd_chk("t5_idx3", 6'd3, 16'h0000, 1'b0);
      repeat (10) @(negedge clk);
      chk("t5_left", 64'(exp_q.size()), 64'h0);

`ifdef PMBUS_POLL_TIMEOUT_EN
      // Engine never answers dev1 cmd0
      withhold = 1'b1;
      push_base();
      pulse_start();
      wait_fh("t6_fh", 2000);
      repeat (2) @(negedge clk);
      chk("t6_left", 64'(exp_q.size()), 64'h0);
      chk("t6_err", {63'h0, err}, 64'h1);
      rd_chk("t6_idx2", 6'd2, 16'hFFFF, 1'b1);
      rd_chk("t6_idx0", 6'd0, 16'h128B, 1'b0);
      rd_chk("t6_idx3", 6'd3, 16'h00AB, 1'b0);
      withhold = 1'b0;
      push_base();
      pulse_start();
      chk("t6_err_clr", {63'h0, err}, 64'h0);
      wait_fh("t6b_fh", 500);
      repeat (2) @(negedge clk);
      rd_chk("t6b_idx2", 6'd2, 16'h348B, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
